// File: rtl/sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sbox_arbiter (with helper aes_sbox)
// Purpose  : Shares a four-lane AES S-box bank between a 128-bit SubBytes
//            request (one word per cycle) and a 32-bit key-schedule SubWord
//            request, with two-way round-robin arbitration.
// Options  : SBOX_KEY_PREEMPT_EN - a pending key request may steal the bank
//            for one cycle while a state operation is in progress.
// Revision : 1.0 - initial release
// ============================================================================

// Combinational AES forward S-box, one byte lane.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] tbl_idx;

  // Entry 0x00 sits in the top byte, so the bit offset is (255 - in) * 8.
  always_comb begin
    tbl_idx  = {~in_byte, 3'b000};
    out_byte = SBOX_TABLE[tbl_idx +: 8];
  end

endmodule

module sbox_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_STW  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] buf_q, buf_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  kw_out_q, kw_out_d;
  logic         st_done_q, st_done_d;
  logic         kw_done_q, kw_done_d;
  logic         busy_q, busy_d;
  logic         last_key_q, last_key_d;

  logic         key_pend;
  logic         st_pend;
  logic         steal;
  logic [31:0]  cur_word;
  logic [31:0]  bank_in;
  logic [31:0]  bank_out;

  // A request seen during its own done pulse is the tail of the finished one.
  always_comb begin
    key_pend = kw_req & ~kw_done_q;
    st_pend  = st_req & ~st_done_q;
  end

`ifdef SBOX_KEY_PREEMPT_EN
  // A steal raises kw_done next cycle, which masks key_pend, so steals never chain.
  always_comb steal = (state_q == S_STW) && key_pend;
`else
  // Key requests wait for IDLE while a state operation runs.
  always_comb steal = 1'b0;
`endif

  // Pick the buffered state word addressed by the counter; word0 is the MSW.
  always_comb begin
    unique case (cnt_q)
      2'd0:    cur_word = buf_q[127:96];
      2'd1:    cur_word = buf_q[95:64];
      2'd2:    cur_word = buf_q[63:32];
      default: cur_word = buf_q[31:0];
    endcase
  end

  // Bank input: key word in IDLE or while stealing, otherwise the state word.
  always_comb bank_in = ((state_q == S_IDLE) || steal) ? kw_in : cur_word;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (bank_in[8*i +: 8]),
        .out_byte (bank_out[8*i +: 8])
      );
    end
  endgenerate

  // Next-state logic: arbitration, word sequencing and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    st_out_d   = st_out_q;
    kw_out_d   = kw_out_q;
    st_done_d  = 1'b0;
    kw_done_d  = 1'b0;
    last_key_d = last_key_q;
    unique case (state_q)
      S_IDLE: begin
        // Key wins a tie unless it also won the previous grant.
        if (key_pend && (!st_pend || !last_key_q)) begin
          kw_out_d   = bank_out;
          last_key_d = 1'b1;
          state_d    = S_KEY;
        end else if (st_pend) begin
          buf_d      = st_in;
          cnt_d      = 2'd0;
          last_key_d = 1'b0;
          state_d    = S_STW;
        end
      end
      S_KEY: begin
        kw_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_STW: begin
        if (steal) begin
          kw_out_d   = bank_out;
          kw_done_d  = 1'b1;
          last_key_d = 1'b1;
        end else begin
          unique case (cnt_q)
            2'd0:    st_out_d[127:96] = bank_out;
            2'd1:    st_out_d[95:64]  = bank_out;
            2'd2:    st_out_d[63:32]  = bank_out;
            default: st_out_d[31:0]   = bank_out;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            st_done_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      buf_q      <= '0;
      st_out_q   <= '0;
      kw_out_q   <= '0;
      st_done_q  <= 1'b0;
      kw_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      last_key_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      st_out_q   <= st_out_d;
      kw_out_q   <= kw_out_d;
      st_done_q  <= st_done_d;
      kw_done_q  <= kw_done_d;
      busy_q     <= busy_d;
      last_key_q <= last_key_d;
    end
  end

  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_arbiter
// Purpose  : Self-checking bench for sbox_arbiter. Expected S-box values come
//            from GF(2^8) inversion plus the affine map; timing expectations
//            come from the operation latencies and round-robin rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_arbiter;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         st_req = 1'b0;
  logic [127:0] st_in  = '0;
  logic         kw_req = 1'b0;
  logic [31:0]  kw_in  = '0;
  logic [127:0] st_out;
  logic [31:0]  kw_out;
  logic         st_done;
  logic         kw_done;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference state of the design's visible history.
  bit           last_key = 1'b0;
  logic [127:0] exp_st   = '0;
  logic [31:0]  exp_kw   = '0;

  always #5 clk = ~clk;

  sbox_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .st_req  (st_req),
    .st_in   (st_in),
    .st_out  (st_out),
    .st_done (st_done),
    .kw_req  (kw_req),
    .kw_in   (kw_in),
    .kw_out  (kw_out),
    .kw_done (kw_done),
    .busy    (busy)
  );

  // ---------------- reference S-box from field arithmetic ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_ref(w[8*b +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = sbox_ref(s[8*b +: 8]);
    return r;
  endfunction

  // First k words (word0 = MSW) from nw, remaining words from old.
  function automatic logic [127:0] mix(input logic [127:0] nw, input logic [127:0] old, input int k);
    logic [127:0] r;
    r = old;
    for (int w = 0; w < 4; w++)
      if (w < k) r[127-32*w -: 32] = nw[127-32*w -: 32];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample just after the edge. Done pulses never overlap.
  task automatic step();
    @(posedge clk);
    #1;
    chk("done_overlap", {127'b0, st_done & kw_done}, 128'b0);
  endtask

  // ---------------- operations ----------------
  task automatic key_op(input logic [31:0] d);
    int n;
    kw_req = 1'b1;
    kw_in  = d;
    step();
    n = 1;
    kw_in = $urandom;                 // only the grant cycle value matters
    chk("key_busy", {127'b0, busy}, 128'd1);
    while (!kw_done && n < 30) begin
      step();
      n++;
    end
    exp_kw = sub_word(d);
    chk("key_latency", n, 2);
    chk("key_out", kw_out, exp_kw);
    kw_req = 1'b0;
    last_key = 1'b1;
    step();
    chk("key_pulse_width", {127'b0, kw_done}, 128'd0);
  endtask

  task automatic st_op(input logic [127:0] d);
    int n;
    int nb;
    logic [127:0] want;
    want   = sub_state(d);
    st_req = 1'b1;
    st_in  = d;
    n = 0;
    nb = 0;
    while (!st_done && n < 30) begin
      step();
      n++;
      st_in = rand128();              // sampled only on the accept edge
      if (busy) nb++;
      if (!st_done && n <= 4) chk("st_partial", st_out, mix(want, exp_st, n - 1));
    end
    exp_st = want;
    chk("st_latency", n, 5);
    chk("st_busy_cycles", nb, 4);
    chk("st_out", st_out, exp_st);
    st_req = 1'b0;
    last_key = 1'b0;
    step();
    chk("st_pulse_width", {127'b0, st_done}, 128'd0);
  endtask

  // Both requests raised together from IDLE; record the done cycles.
  task automatic both_op(input logic [127:0] ds, input logic [31:0] dk);
    int n;
    int tk;
    int ts;
    bit key_first;
    key_first = !last_key;
    st_req = 1'b1; kw_req = 1'b1; st_in = ds; kw_in = dk;
    n = 0; tk = -1; ts = -1;
    while ((tk < 0 || ts < 0) && n < 40) begin
      step();
      n++;
      if (kw_done) begin tk = n; kw_req = 1'b0; end
      if (st_done) begin ts = n; st_req = 1'b0; end
    end
    if (key_first) begin
      chk("both_key_done", tk, 2);
      chk("both_st_done", ts, 7);
      last_key = 1'b0;
    end else begin
`ifdef SBOX_KEY_PREEMPT_EN
      chk("both_key_done", tk, 2);
      chk("both_st_done", ts, 6);
`else
      chk("both_key_done", tk, 7);
      chk("both_st_done", ts, 5);
`endif
      last_key = 1'b1;
    end
    exp_st = sub_state(ds);
    exp_kw = sub_word(dk);
    chk("both_st_out", st_out, exp_st);
    chk("both_kw_out", kw_out, exp_kw);
    step();
  endtask

  // Key request raised while the state op is on word 1.
  task automatic preempt_op(input logic [127:0] ds, input logic [31:0] dk);
    int n;
    int tk;
    int ts;
    st_req = 1'b1; st_in = ds;
    n = 0; tk = -1; ts = -1;
    while ((tk < 0 || ts < 0) && n < 40) begin
      step();
      n++;
      if (n == 2) begin kw_req = 1'b1; kw_in = dk; end
      if (kw_done) begin tk = n; kw_req = 1'b0; end
      if (st_done) begin ts = n; st_req = 1'b0; end
    end
`ifdef SBOX_KEY_PREEMPT_EN
    chk("pre_key_done", tk, 3);
    chk("pre_st_done", ts, 6);
`else
    chk("pre_key_done", tk, 7);
    chk("pre_st_done", ts, 5);
`endif
    exp_st = sub_state(ds);
    exp_kw = sub_word(dk);
    chk("pre_st_out", st_out, exp_st);
    chk("pre_kw_out", kw_out, exp_kw);
    last_key = 1'b1;
    step();
  endtask

  task automatic reset_mid_op(input logic [127:0] ds);
    int nd;
    st_req = 1'b1; st_in = ds;
    step(); step(); step();           // counter now at word 2
    rst_n = 1'b0;
    st_req = 1'b0;
    #1;
    chk("rst_st_out", st_out, 128'd0);
    chk("rst_kw_out", {96'b0, kw_out}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_st_done", {127'b0, st_done}, 128'd0);
    chk("rst_kw_done", {127'b0, kw_done}, 128'd0);
    step();
    rst_n = 1'b1;
    exp_st = '0; exp_kw = '0; last_key = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (st_done) nd++;
    end
    chk("rst_no_done", nd, 0);
  endtask

  task automatic back_to_back(input logic [127:0] d1, input logic [127:0] d2);
    int n;
    st_req = 1'b1; st_in = d1; n = 0;
    while (!st_done && n < 30) begin step(); n++; end
    chk("b2b_first_done", n, 5);
    chk("b2b_first_out", st_out, sub_state(d1));
    st_in = d2;                       // request stays high
    step(); n++;
    chk("b2b_gap_busy", {127'b0, busy}, 128'd0);
    step(); n++;
    chk("b2b_second_busy", {127'b0, busy}, 128'd1);
    while (!st_done && n < 40) begin step(); n++; end
    chk("b2b_second_done", n, 11);
    exp_st = sub_state(d2);
    chk("b2b_second_out", st_out, exp_st);
    st_req = 1'b0;
    last_key = 1'b0;
    step();
  endtask

  // ---------------- sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_st_out", st_out, 128'd0);
    chk("reset_kw_out", {96'b0, kw_out}, 128'd0);
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_done", {126'b0, st_done, kw_done}, 128'd0);
    rst_n = 1'b1;
    step();

    key_op(32'h00010253);
    chk("known_kw", {96'b0, kw_out}, {96'b0, 32'h637c77ed});

    st_op('0);
    chk("known_st", st_out, {16{8'h63}});

    both_op({16{8'h53}}, $urandom);   // last grant was state: key first
    chk("known_both_st", st_out, {16{8'hed}});

    key_op($urandom);
    both_op(rand128(), $urandom);     // last grant was key: state first

    preempt_op(rand128(), $urandom);

    reset_mid_op(rand128());
    st_op(rand128());

    back_to_back(rand128(), rand128());

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: key_op($urandom);
        1: st_op(rand128());
        2: both_op(rand128(), $urandom);
        default: repeat ($urandom_range(1, 4)) step();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
